// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning channel multiplexer.
package mux_scan_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } mode_t;

  // Keeps select and counter widths at one bit or more, even for tiny parameters.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N-way channel select with an in-range flag; the generalised lab mux.
module mux_n
  import mux_scan_pkg::*;
#(
  parameter int N_CH = 5,
  parameter int W    = 1,
  parameter int SELW = clog2_min1(N_CH)
) (
  input  logic [N_CH*W-1:0] x,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      y,
  output logic              valid
);

  // Codes at or above N_CH fall through to zero.
  always_comb begin
    y = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SELW'(k)) begin
        y = x[k*W +: W];
      end
    end
  end

  assign valid = (int'(sel) < N_CH);

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with manual select and round-robin auto-scan.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 5,
  parameter int W     = 1,
  parameter int DWELL = 50_000_000,
  parameter int SELW  = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] x,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic              hold,
  output logic [W-1:0]      m_out,
  output logic [SELW-1:0]   ch,
  output logic              sel_err,
  output logic              step
);

  localparam int              CW       = clog2_min1(DWELL + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(N_CH - 1);

  mode_t           state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0] ch_d, ch_inc, idx;
  logic            sel_err_d, step_d;
  logic            at_last, advance;
  logic [W-1:0]    mux_y;
  logic            mux_ok;

  assign at_last = (cnt_q == LAST_CNT);
  assign ch_inc  = (ch == LAST_CH) ? '0 : ch + SELW'(1);
  assign advance = mode && (state_q == SCAN) && !hold && at_last;

  // The mux looks at the channel ch will hold after this edge, so m_out and ch stay paired.
  assign idx = !mode ? sel : (advance ? ch_inc : ch);

  mux_n #(
    .N_CH (N_CH),
    .W    (W),
    .SELW (SELW)
  ) u_mux (
    .x     (x),
    .sel   (idx),
    .y     (mux_y),
    .valid (mux_ok)
  );

  always_comb begin
    state_d   = mode ? SCAN : MANUAL;
    cnt_d     = '0;
    ch_d      = ch;
    sel_err_d = 1'b0;
    step_d    = 1'b0;
    if (!mode) begin
      ch_d      = mux_ok ? sel : '0;
      sel_err_d = !mux_ok;
    end else if (state_q == SCAN) begin
      // The first scan cycle (coming from MANUAL) keeps ch and restarts the dwell count.
      if (hold) begin
        cnt_d = cnt_q;
      end else if (at_last) begin
        ch_d   = ch_inc;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MANUAL;
      cnt_q   <= '0;
      ch      <= '0;
      m_out   <= '0;
      sel_err <= 1'b0;
      step    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch      <= ch_d;
      m_out   <= mux_y;
      sel_err <= sel_err_d;
      step    <= step_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: a 5x4-bit DWELL=3 instance and a 2x1-bit DWELL=1 instance.
module tb_mux_scan_n;

  localparam int A_NCH = 5, A_W = 4, A_DWELL = 3;
  localparam int B_NCH = 2, B_W = 1, B_DWELL = 1;
  localparam logic [19:0] A_X0 = {4'hE, 4'hD, 4'hC, 4'hB, 4'hA};

  typedef struct packed {
    bit scan;
    int ch;
    int cnt;
  } mstate_t;

  typedef struct packed {
    logic [31:0] m_out;
    logic [31:0] ch;
    logic [31:0] sel_err;
    logic [31:0] step;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, mode_a, hold_a;
  logic [19:0] x_a;
  logic [2:0]  sel_a;
  logic [3:0]  m_out_a;
  logic [2:0]  ch_a;
  logic        sel_err_a, step_a;

  logic        rst_b, mode_b, hold_b;
  logic [1:0]  x_b;
  logic [0:0]  sel_b;
  logic [0:0]  m_out_b;
  logic [0:0]  ch_b;
  logic        sel_err_b, step_b;

  int checks_total  = 0;
  int checks_passed = 0;

  mstate_t st_a, st_b;
  exp_t    q_a[$];
  exp_t    q_b[$];
  exp_t    ea, eb;

  int wrap_ch[10] = '{3, 3, 3, 4, 4, 4, 0, 0, 0, 1};

  mux_scan_n #(.N_CH(A_NCH), .W(A_W), .DWELL(A_DWELL)) dut_a (
    .clk(clk), .rst(rst_a), .x(x_a), .sel(sel_a), .mode(mode_a), .hold(hold_a),
    .m_out(m_out_a), .ch(ch_a), .sel_err(sel_err_a), .step(step_a)
  );

  mux_scan_n #(.N_CH(B_NCH), .W(B_W), .DWELL(B_DWELL)) dut_b (
    .clk(clk), .rst(rst_b), .x(x_b), .sel(sel_b), .mode(mode_b), .hold(hold_b),
    .m_out(m_out_b), .ch(ch_b), .sel_err(sel_err_b), .step(step_b)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] chan(input logic [63:0] xb, input int k, input int w);
    return 32'((xb >> (k * w)) & ((64'd1 << w) - 64'd1));
  endfunction

  // Behavioural model: what the block should show after one clock edge.
  function automatic void model_step(input mstate_t si, input int n_ch, input int dwell, input int w,
                                     input bit r, input logic [63:0] xb, input int s,
                                     input bit md, input bit hd,
                                     output mstate_t so, output exp_t e);
    so = si;
    e  = '0;
    if (r) begin
      so = '0;
      return;
    end
    if (!md) begin
      so.scan = 1'b0;
      so.cnt  = 0;
      if (s < n_ch) begin
        so.ch   = s;
        e.m_out = chan(xb, s, w);
      end else begin
        so.ch     = 0;
        e.sel_err = 1;
      end
    end else if (!si.scan) begin
      so.scan = 1'b1;
      so.cnt  = 0;
      e.m_out = chan(xb, so.ch, w);
    end else begin
      if (!hd) begin
        if (si.cnt + 1 == dwell) begin
          so.cnt = 0;
          so.ch  = (si.ch + 1) % n_ch;
          e.step = 1;
        end else begin
          so.cnt = si.cnt + 1;
        end
      end
      e.m_out = chan(xb, so.ch, w);
    end
    e.ch = 32'(so.ch);
  endfunction

  // Predict both instances for the inputs now applied, then let one edge pass.
  task automatic apply_stimulus();
    mstate_t ns;
    exp_t    e;
    model_step(st_a, A_NCH, A_DWELL, A_W, rst_a, 64'(x_a), int'(sel_a), mode_a, hold_a, ns, e);
    st_a = ns;
    q_a.push_back(e);
    model_step(st_b, B_NCH, B_DWELL, B_W, rst_b, 64'(x_b), int'(sel_b), mode_b, hold_b, ns, e);
    st_b = ns;
    q_b.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (q_a.size() != 0) begin
      ea = q_a.pop_front();
      check_output("a_m_out", 32'(m_out_a), ea.m_out);
      check_output("a_ch", 32'(ch_a), ea.ch);
      check_output("a_sel_err", 32'(sel_err_a), ea.sel_err);
      check_output("a_step", 32'(step_a), ea.step);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (q_b.size() != 0) begin
      eb = q_b.pop_front();
      check_output("b_m_out", 32'(m_out_b), eb.m_out);
      check_output("b_ch", 32'(ch_b), eb.ch);
      check_output("b_sel_err", 32'(sel_err_b), eb.sel_err);
      check_output("b_step", 32'(step_b), eb.step);
    end
  end

  initial begin
    st_a = '0;
    st_b = '0;
    rst_a = 1'b1; mode_a = 1'b0; hold_a = 1'b0; sel_a = 3'd3; x_a = A_X0;
    rst_b = 1'b1; mode_b = 1'b0; hold_b = 1'b0; sel_b = 1'b0; x_b = 2'b10;

    repeat (3) begin
      apply_stimulus();
      check_output("rst_m_out", 32'(m_out_a), 32'h0);
      check_output("rst_ch", 32'(ch_a), 32'h0);
    end
    rst_a = 1'b0;
    apply_stimulus();
    check_output("post_rst_m_out", 32'(m_out_a), 32'hD);
    check_output("post_rst_ch", 32'(ch_a), 32'd3);
    check_output("post_rst_sel_err", 32'(sel_err_a), 32'd0);

    sel_a = 3'd6;
    apply_stimulus();
    check_output("oor_m_out", 32'(m_out_a), 32'h0);
    check_output("oor_ch", 32'(ch_a), 32'd0);
    check_output("oor_sel_err", 32'(sel_err_a), 32'd1);
    sel_a = 3'd4;
    apply_stimulus();
    check_output("sel4_m_out", 32'(m_out_a), 32'hE);
    check_output("sel4_sel_err", 32'(sel_err_a), 32'd0);

    sel_a = 3'd3;
    apply_stimulus();
    mode_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus();
      check_output("wrap_ch", 32'(ch_a), 32'(wrap_ch[i]));
      check_output("wrap_step", 32'(step_a), (i > 0 && wrap_ch[i] != wrap_ch[i-1]) ? 32'd1 : 32'd0);
      check_output("wrap_m_out", 32'(m_out_a), 32'(10 + wrap_ch[i]));
    end

    apply_stimulus();
    check_output("pre_hold_ch", 32'(ch_a), 32'd1);
    hold_a = 1'b1;
    repeat (5) begin
      x_a = 20'($urandom);
      apply_stimulus();
      check_output("hold_ch", 32'(ch_a), 32'd1);
      check_output("hold_step", 32'(step_a), 32'd0);
      check_output("hold_live_m_out", 32'(m_out_a), chan(64'(x_a), 1, A_W));
    end
    x_a = A_X0;
    hold_a = 1'b0;
    apply_stimulus();
    check_output("release1_ch", 32'(ch_a), 32'd1);
    check_output("release1_step", 32'(step_a), 32'd0);
    apply_stimulus();
    check_output("release2_ch", 32'(ch_a), 32'd2);
    check_output("release2_step", 32'(step_a), 32'd1);

    rst_a = 1'b1;
    apply_stimulus();
    check_output("midrst_ch", 32'(ch_a), 32'd0);
    check_output("midrst_m_out", 32'(m_out_a), 32'h0);
    check_output("midrst_step", 32'(step_a), 32'd0);
    rst_a = 1'b0; mode_a = 1'b0; sel_a = 3'd2;
    apply_stimulus();
    check_output("after_rst_m_out", 32'(m_out_a), 32'hC);
    check_output("after_rst_ch", 32'(ch_a), 32'd2);

    rst_b = 1'b0; mode_b = 1'b1;
    apply_stimulus();
    check_output("d1_entry_ch", 32'(ch_b), 32'd0);
    check_output("d1_entry_step", 32'(step_b), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus();
      check_output("d1_ch", 32'(ch_b), 32'(i % 2));
      check_output("d1_m_out", 32'(m_out_b), 32'(i % 2));
      check_output("d1_step", 32'(step_b), 32'd1);
    end

    for (int i = 0; i < 400; i++) begin
      rst_a  = ($urandom_range(0, 49) == 0);
      mode_a = ($urandom_range(0, 3) != 0);
      hold_a = ($urandom_range(0, 3) == 0);
      sel_a  = 3'($urandom);
      x_a    = 20'($urandom);
      rst_b  = ($urandom_range(0, 49) == 0);
      mode_b = ($urandom_range(0, 3) != 0);
      hold_b = ($urandom_range(0, 3) == 0);
      sel_b  = 1'($urandom);
      x_b    = 2'($urandom);
      apply_stimulus();
    end

    #4;
    check_output("a_queue_drain", 32'(q_a.size()), 32'd0);
    check_output("b_queue_drain", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
